// File: rtl/mixer_seq.sv
`default_nettype none
// ============================================================================
// Module      : mixer_seq
// Description : Time-multiplexed stereo mixer: one channel per clk28 through a
//               shared volume multiplier, saturated per-frame latch, and
//               first-order sigma-delta 1-bit DAC outputs.
//               Optional: MIXER_CLIP_FLAG_EN enables sticky clip flags.
// Revision    : 1.0 - initial release
// ============================================================================
module mixer_seq #(
    parameter int CHANNELS = 8,
    parameter int IN_W     = 8,
    parameter int VOL_W    = 4,
    parameter int DAC_W    = 12,
    parameter int SHIFT    = 2
) (
    input  logic                      clk28,
    input  logic                      rst,
    input  logic [CHANNELS*IN_W-1:0]  ch_data,
    input  logic [CHANNELS*VOL_W-1:0] ch_vol,
    input  logic [CHANNELS*2-1:0]     ch_pan,
    input  logic                      mono,
    input  logic                      mute,
    input  logic                      clip_clr,
    output logic [DAC_W-1:0]          sample_l,
    output logic [DAC_W-1:0]          sample_r,
    output logic                      sample_stb,
    output logic                      clip_l,
    output logic                      clip_r,
    output logic                      dac_l,
    output logic                      dac_r
);

    localparam int C_IDX_W  = $clog2(CHANNELS);
    localparam int C_PROD_W = IN_W + VOL_W;
    localparam int C_ACC_W  = C_PROD_W + $clog2(CHANNELS);
    localparam int C_CMP_W  = (C_ACC_W > DAC_W) ? C_ACC_W : DAC_W;
    localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(CHANNELS - 1);
    localparam logic [C_CMP_W-1:0] C_SAT_MAX  = C_CMP_W'({DAC_W{1'b1}});

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        LATCH = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [C_IDX_W-1:0]   r_idx;
    logic [C_ACC_W-1:0]   r_acc_l;
    logic [C_ACC_W-1:0]   r_acc_r;
    logic [DAC_W-1:0]     r_sample_l;
    logic [DAC_W-1:0]     r_sample_r;
    logic                 r_stb;
    logic [DAC_W:0]       r_cnt_l;
    logic [DAC_W:0]       r_cnt_r;

    logic [IN_W-1:0]      w_data;
    logic [VOL_W-1:0]     w_vol;
    logic [1:0]           w_pan;
    logic [C_PROD_W-1:0]  w_prod;
    logic [C_ACC_W-1:0]   w_shift_l;
    logic [C_ACC_W-1:0]   w_shift_r;
    logic [C_CMP_W-1:0]   w_cmp_l;
    logic [C_CMP_W-1:0]   w_cmp_r;
    logic                 w_sat_flag_l;
    logic                 w_sat_flag_r;
    logic [DAC_W-1:0]     w_sat_l;
    logic [DAC_W-1:0]     w_sat_r;
    logic [DAC_W:0]       w_sum;
    logic [DAC_W-1:0]     w_out_l;
    logic [DAC_W-1:0]     w_out_r;
    logic                 w_latch;

    // Channel select and exact product for the channel indexed this cycle
    assign w_data = ch_data[r_idx*IN_W +: IN_W];
    assign w_vol  = ch_vol[r_idx*VOL_W +: VOL_W];
    assign w_pan  = ch_pan[r_idx*2 +: 2];
    assign w_prod = C_PROD_W'(w_data) * C_PROD_W'(w_vol);

    assign w_shift_l    = r_acc_l >> SHIFT;
    assign w_shift_r    = r_acc_r >> SHIFT;
    assign w_cmp_l      = C_CMP_W'(w_shift_l);
    assign w_cmp_r      = C_CMP_W'(w_shift_r);
    assign w_sat_flag_l = (w_cmp_l > C_SAT_MAX);
    assign w_sat_flag_r = (w_cmp_r > C_SAT_MAX);
    assign w_sat_l      = w_sat_flag_l ? {DAC_W{1'b1}} : w_cmp_l[DAC_W-1:0];
    assign w_sat_r      = w_sat_flag_r ? {DAC_W{1'b1}} : w_cmp_r[DAC_W-1:0];

    // Mono downmix is taken after saturation; mute overrides everything
    assign w_sum   = {1'b0, w_sat_l} + {1'b0, w_sat_r};
    assign w_out_l = mute ? '0 : (mono ? w_sum[DAC_W:1] : w_sat_l);
    assign w_out_r = mute ? '0 : (mono ? w_sum[DAC_W:1] : w_sat_r);

    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        case (r_state)
            ACCUM: begin
                if (r_idx == C_LAST_IDX) begin
                    w_next = LATCH;
                end
            end
            LATCH: begin
                w_latch = 1'b1;
                w_next  = ACCUM;
            end
            default: w_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            r_state <= ACCUM;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk28) begin
        if (rst) begin
            r_idx      <= '0;
            r_acc_l    <= '0;
            r_acc_r    <= '0;
            r_sample_l <= '0;
            r_sample_r <= '0;
            r_stb      <= 1'b0;
            r_cnt_l    <= '0;
            r_cnt_r    <= '0;
        end else begin
            r_stb <= 1'b0;
            if (w_latch) begin
                r_sample_l <= w_out_l;
                r_sample_r <= w_out_r;
                r_stb      <= 1'b1;
                r_acc_l    <= '0;
                r_acc_r    <= '0;
                r_idx      <= '0;
            end else begin
                if (w_pan[0]) begin
                    r_acc_l <= r_acc_l + C_ACC_W'(w_prod);
                end
                if (w_pan[1]) begin
                    r_acc_r <= r_acc_r + C_ACC_W'(w_prod);
                end
                r_idx <= r_idx + C_IDX_W'(1);
            end
            // Carry out of the phase accumulator is the 1-bit DAC stream
            r_cnt_l <= {1'b0, r_cnt_l[DAC_W-1:0]} + {1'b0, r_sample_l};
            r_cnt_r <= {1'b0, r_cnt_r[DAC_W-1:0]} + {1'b0, r_sample_r};
        end
    end

`ifdef MIXER_CLIP_FLAG_EN
    logic r_clip_l;
    logic r_clip_r;

    // A saturating latch takes priority over a simultaneous clear
    always_ff @(posedge clk28) begin
        if (rst) begin
            r_clip_l <= 1'b0;
            r_clip_r <= 1'b0;
        end else begin
            if (w_latch && w_sat_flag_l) begin
                r_clip_l <= 1'b1;
            end else if (clip_clr) begin
                r_clip_l <= 1'b0;
            end
            if (w_latch && w_sat_flag_r) begin
                r_clip_r <= 1'b1;
            end else if (clip_clr) begin
                r_clip_r <= 1'b0;
            end
        end
    end

    assign clip_l = r_clip_l;
    assign clip_r = r_clip_r;
`else
    logic w_unused_clip_clr;
    assign w_unused_clip_clr = clip_clr;
    assign clip_l = 1'b0;
    assign clip_r = 1'b0;
`endif

    assign sample_l   = r_sample_l;
    assign sample_r   = r_sample_r;
    assign sample_stb = r_stb;
    assign dac_l      = r_cnt_l[DAC_W];
    assign dac_r      = r_cnt_r[DAC_W];

endmodule
`default_nettype wire

// File: tb/tb_mixer_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mixer_seq
// Description : Self-checking bench for mixer_seq (default and small configs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mixer_seq;

    localparam int CH    = 8;
    localparam int SHIFT = 2;
    localparam int SMAX  = 4095;
`ifdef MIXER_CLIP_FLAG_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] ch_data;
    logic [31:0] ch_vol;
    logic [15:0] ch_pan;
    logic        mono, mute, clip_clr;
    logic [11:0] sample_l, sample_r;
    logic        sample_stb, clip_l, clip_r, dac_l, dac_r;

    logic [29:0] p_data = 30'h3FF << 10;
    logic [5:0]  p_vol  = 6'b001100;
    logic [5:0]  p_pan  = 6'b001000;
    logic        p_zero = 1'b0;
    logic [9:0]  p_sample_l, p_sample_r;
    logic        p_stb, p_clip_l, p_clip_r, p_dac_l, p_dac_r;

    always #5 clk = ~clk;

    mixer_seq dut (
        .clk28(clk), .rst(rst), .ch_data(ch_data), .ch_vol(ch_vol), .ch_pan(ch_pan),
        .mono(mono), .mute(mute), .clip_clr(clip_clr),
        .sample_l(sample_l), .sample_r(sample_r), .sample_stb(sample_stb),
        .clip_l(clip_l), .clip_r(clip_r), .dac_l(dac_l), .dac_r(dac_r)
    );

    mixer_seq #(.CHANNELS(3), .IN_W(10), .VOL_W(2), .DAC_W(10), .SHIFT(0)) dut_p (
        .clk28(clk), .rst(rst), .ch_data(p_data), .ch_vol(p_vol), .ch_pan(p_pan),
        .mono(p_zero), .mute(p_zero), .clip_clr(p_zero),
        .sample_l(p_sample_l), .sample_r(p_sample_r), .sample_stb(p_stb),
        .clip_l(p_clip_l), .clip_r(p_clip_r), .dac_l(p_dac_l), .dac_r(p_dac_r)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Small configuration: frame of 4 cycles, channel 1 saturates the right side
    int pn = 0;
    always @(posedge clk) pn <= rst ? 0 : pn + 1;
    always @(negedge clk) begin
        check("p_stb", p_stb, (pn > 0 && pn % 4 == 0));
        check("p_sample_l", p_sample_l, 0);
        check("p_sample_r", p_sample_r, (pn >= 4) ? 1023 : 0);
        check("p_clip_l", p_clip_l, 0);
        check("p_clip_r", p_clip_r, (CLIP_EN && pn >= 4));
    end

    // Ones-density window for the DAC streams
    bit win_en = 1'b0;
    int win = 0, ones_l = 0, ones_r = 0;
    always @(negedge clk) begin
        if (win_en && win < 4096) begin
            win++;
            ones_l += dac_l;
            ones_r += dac_r;
        end
    end

    int exp_l, exp_r, f_ones_l, f_ones_r;
    bit exp_clip_l, exp_clip_r;

    task automatic model_reset();
        exp_l = 0; exp_r = 0; exp_clip_l = 1'b0; exp_clip_r = 1'b0;
    endtask

    task automatic randomize_inputs();
        logic [31:0] t;
        ch_data = {$urandom, $urandom};
        ch_vol  = $urandom;
        t       = $urandom;
        ch_pan  = t[15:0];
        clip_clr = ($urandom_range(0, 7) == 0);
    endtask

    task automatic check_hold(input bit stb_exp);
        check("stb", sample_stb, stb_exp);
        check("sample_l", sample_l, exp_l);
        check("sample_r", sample_r, exp_r);
        check("clip_l", clip_l, CLIP_EN & exp_clip_l);
        check("clip_r", clip_r, CLIP_EN & exp_clip_r);
    endtask

    // One frame aligned to the DUT: CH accumulate cycles, then the latch cycle
    task automatic frame(input bit rnd, input bit clr_first, input bit clr_latch);
        int al = 0, ar = 0, sl, sr, d, v;
        bit stl, str;
        f_ones_l = 0; f_ones_r = 0;
        for (int c = 0; c < CH; c++) begin
            if (rnd) randomize_inputs();
            else clip_clr = clr_first && (c == 0);
            d = int'(ch_data[c*8 +: 8]);
            v = int'(ch_vol[c*4 +: 4]);
            if (ch_pan[2*c])   al += d * v;
            if (ch_pan[2*c+1]) ar += d * v;
            if (clip_clr) begin exp_clip_l = 1'b0; exp_clip_r = 1'b0; end
            @(negedge clk);
            f_ones_l += dac_l; f_ones_r += dac_r;
            check_hold(1'b0);
        end
        if (rnd) begin
            randomize_inputs();
            mono = ($urandom_range(0, 3) == 0);
            mute = ($urandom_range(0, 5) == 0);
        end else begin
            clip_clr = clr_latch;
        end
        sl = al >> SHIFT; sr = ar >> SHIFT;
        stl = (sl > SMAX); str = (sr > SMAX);
        if (stl) sl = SMAX;
        if (str) sr = SMAX;
        if (mono) begin sl = (sl + sr) / 2; sr = sl; end
        if (mute) begin sl = 0; sr = 0; end
        if (stl) exp_clip_l = 1'b1; else if (clip_clr) exp_clip_l = 1'b0;
        if (str) exp_clip_r = 1'b1; else if (clip_clr) exp_clip_r = 1'b0;
        exp_l = sl; exp_r = sr;
        @(negedge clk);
        f_ones_l += dac_l; f_ones_r += dac_r;
        check_hold(1'b1);
    endtask

    typedef struct {
        logic [63:0] data;
        logic [31:0] vol;
        logic [15:0] pan;
        bit          mono;
        bit          mute;
        int          exp_l;
        int          exp_r;
        bit          sat_l;
        bit          sat_r;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{64'hFF, 32'hF, 16'h0001, 0, 0, 956, 0, 0, 0};
        tbl[1]  = '{64'hFF, 32'hF, 16'h0002, 0, 0, 0, 956, 0, 0};
        tbl[2]  = '{64'hFF, 32'hF, 16'h0001, 1, 0, 478, 478, 0, 0};
        tbl[3]  = '{64'hFF, 32'hF, 16'h0001, 1, 1, 0, 0, 0, 0};
        tbl[4]  = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 0, 0, 4095, 4095, 1, 1};
        tbl[5]  = '{64'h0, 32'h0, 16'h0, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{64'hC800_0064, 32'h0000_500A, 16'h00C1, 0, 0, 500, 250, 0, 0};
        tbl[7]  = '{64'hC800_0064, 32'h0000_500A, 16'h00C1, 1, 0, 375, 375, 0, 0};
        tbl[8]  = '{64'hFF, 32'h0, 16'h0003, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{64'h8000_0000_0000_0000, 32'h8000_0000, 16'h8000, 0, 0, 0, 256, 0, 0};
        tbl[10] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 16'h5555, 0, 0, 4095, 0, 1, 0};
        tbl[11] = '{64'h0000_0048_FFFF_FFFF, 32'h000F_FFFF, 16'h0155, 0, 0, 4095, 0, 0, 0};
        tbl[12] = '{64'h0000_0049_FFFF_FFFF, 32'h000F_FFFF, 16'h0155, 0, 0, 4095, 0, 1, 0};

        rst = 1'b1; ch_data = '0; ch_vol = '0; ch_pan = '0;
        mono = 1'b0; mute = 1'b0; clip_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_stb", sample_stb, 0);
        check("rst_sample_l", sample_l, 0);
        check("rst_sample_r", sample_r, 0);
        check("rst_clip_l", clip_l, 0);
        check("rst_clip_r", clip_r, 0);
        check("rst_dac_l", dac_l, 0);
        check("rst_dac_r", dac_r, 0);
        rst = 1'b0;
        model_reset();

        foreach (tbl[i]) begin
            ch_data = tbl[i].data; ch_vol = tbl[i].vol; ch_pan = tbl[i].pan;
            mono = tbl[i].mono; mute = tbl[i].mute;
            frame(1'b0, 1'b1, 1'b0);
            check($sformatf("tbl%0d_l", i), sample_l, tbl[i].exp_l);
            check($sformatf("tbl%0d_r", i), sample_r, tbl[i].exp_r);
            check($sformatf("tbl%0d_clip_l", i), clip_l, CLIP_EN & tbl[i].sat_l);
            check($sformatf("tbl%0d_clip_r", i), clip_r, CLIP_EN & tbl[i].sat_r);
        end
        mono = 1'b0; mute = 1'b0;

        // Clear coinciding with a saturating latch: the set must win
        ch_data = '1; ch_vol = '1; ch_pan = '1;
        frame(1'b0, 1'b0, 1'b1);
        check("setwins_clip_l", clip_l, CLIP_EN);
        check("setwins_clip_r", clip_r, CLIP_EN);
        ch_data = '0; ch_vol = '0; ch_pan = '0;
        frame(1'b0, 1'b0, 1'b1);
        check("clr_clip_l", clip_l, 0);
        check("clr_clip_r", clip_r, 0);

        // Muted output: DAC streams go quiet once the counter stops carrying
        ch_data = 64'hFF; ch_vol = 32'hF; ch_pan = 16'h0001; mute = 1'b1;
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        check("mute_dac_l_ones", f_ones_l, 0);
        check("mute_dac_r_ones", f_ones_r, 0);
        mute = 1'b0;

        // Ones density over a 4096-cycle window
        frame(1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        win_en = 1'b1;
        repeat (456) frame(1'b0, 1'b0, 1'b0);
        check("win_len", win, 4096);
        check("dac_l_ones", ones_l, 956);
        check("dac_r_ones", ones_r, 0);

        // Reset in the middle of a fully active frame
        ch_data = '1; ch_vol = '1; ch_pan = '1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_stb", sample_stb, 0);
        check("midrst_l", sample_l, 0);
        check("midrst_r", sample_r, 0);
        check("midrst_clip_l", clip_l, 0);
        rst = 1'b0;
        model_reset();
        ch_data = 64'hFF; ch_vol = 32'hF; ch_pan = 16'h0001;
        frame(1'b0, 1'b0, 1'b0);
        check("postrst_l", sample_l, 956);
        check("postrst_r", sample_r, 0);

        repeat (80) frame(1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=%0d required=%0d", checks, 0);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/mixer_seq.md
# mixer_seq

Parametrised, time-multiplexed stereo audio mixer with per-channel volume and panning, saturation, and first-order sigma-delta 1-bit DAC outputs. It scans CHANNELS input sources one per clk28 cycle through a single shift-add volume multiplier, latches a saturated stereo sample once per frame, and drives it to the board's PWM/RC DAC pins. It sits between the sound sources (AY, SounDrive, beeper/tape) and the audio output pins.

## Interface
- CHANNELS, 8: number of mono input channels, ≥2.
- IN_W, 8: input sample width, unsigned.
- VOL_W, 4: per-channel volume width; 0 = silent, 2^VOL_W-1 = full.
- DAC_W, 12: latched sample and sigma-delta accumulator width.
- SHIFT, 2: right shift applied to the accumulator before saturation.
- clk28  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- ch_data  in  CHANNELS*IN_W  packed samples; channel k at [k*IN_W +: IN_W].
- ch_vol  in  CHANNELS*VOL_W  packed volumes, same packing.
- ch_pan  in  CHANNELS*2  per channel: bit0 routes to left, bit1 routes to right.
- mono  in  1  downmix latched L/R to (L+R)>>1 on both sides.
- mute  in  1  force latched samples to 0.
- clip_clr  in  1  clear sticky clip flags.
- sample_l, sample_r  out  DAC_W  latched stereo sample.
- sample_stb  out  1  one-cycle pulse when sample_l/r update.
- clip_l, clip_r  out  1  sticky saturation flags.
- dac_l, dac_r  out  1  sigma-delta bitstreams.

## Operation
- ACC_W = IN_W+VOL_W+clog2(CHANNELS); accumulators acc_l, acc_r unsigned ACC_W bits, never overflow.
- FSM states: ACCUM, LATCH.
- ACCUM: channel index idx selects channel idx; product p = data*vol (IN_W+VOL_W bits, exact); acc_l += p if pan[0], acc_r += p if pan[1]. Inputs are read on the cycle their channel is indexed. idx increments; at idx = CHANNELS-1 go to LATCH.
- LATCH: s = acc>>SHIFT; if s > 2^DAC_W-1 then s = 2^DAC_W-1 and clip side set. Apply mono ((sat_l+sat_r)>>1, post-saturation), then mute (0). Register into sample_l/r, pulse sample_stb, clear accumulators, idx = 0, go to ACCUM.
- Sigma-delta, every cycle per side: cnt (DAC_W+1 bits) <= cnt[DAC_W-1:0] + sample; dac = cnt[DAC_W]. Ones density over 2^DAC_W cycles = sample/2^DAC_W exactly.
- Clip flags: set in LATCH, cleared by clip_clr; simultaneous set and clear → set wins.
- Reset values: state ACCUM, idx 0, acc 0, sample_l/r 0, sample_stb 0, clip_l/r 0, cnt 0, dac_l/r 0.

## Timing
- Frame = CHANNELS+1 cycles (CHANNELS ACCUM + 1 LATCH); default 9 cycles, ~3.11 MHz sample rate.
- sample_stb high in the cycle after LATCH; sample_l/r valid in that same cycle and held for the whole frame.
- dac outputs registered; a new sample affects dac one cycle after sample_l/r changes.
- First sample_stb is at cycle CHANNELS+1 after rst deasserts (cycle 1 = first ACCUM).
- rst mid-frame: aborts frame, discards partial accumulators, clears all state; no sample_stb produced for the aborted frame.
- Input changes mid-frame: each channel contributes the value present on its own ACCUM cycle.

## Configuration
- MIXER_CLIP_FLAG_EN defined: clip_l/clip_r implemented as above.
- Not defined: clip_l/clip_r tied to 0, clip_clr ignored; saturation of samples still performed.

## Test plan
- Reset: hold rst 3 cycles, all inputs 0 → every output 0; release → sample_stb first at cycle 9, then every 9 cycles.
- Single channel: ch0 = 255, vol 15, pan 01, others 0 → sample_l = 956, sample_r = 0; dac_l has exactly 956 ones in any 4096-cycle window.
- Saturation: all 8 channels 255, vol 15, pan 11 → sample_l = sample_r = 4095, clip_l = clip_r = 1 (with MIXER_CLIP_FLAG_EN); pulse clip_clr with inputs zeroed → flags 0; clip_clr in same cycle as saturating LATCH → flags stay 1.
- Mono/mute: single-channel case with mono = 1 → both samples 478; add mute = 1 → both 0 at next sample_stb, dac_l/r constant 0 after counter drain.
- Mid-frame reset: assert rst at idx 4 with all channels active → no stale sample; after release, next sample_stb at cycle 9 with value computed only from post-reset inputs.
- Parametrised: CHANNELS = 3, IN_W = 10, VOL_W = 2, DAC_W = 10, SHIFT = 0; ch1 = 1023, vol 3, pan 10 → sample_r = 1023, clip_r = 1, frame = 4 cycles.
